// File: rtl/ppg_pkg.sv
// Shared types and constants for the CCD vertical transfer sequencer.
package ppg_pkg;

  localparam int unsigned VCON_DW = 16;
  localparam int unsigned APB_AW  = 32;
  localparam int unsigned APB_DW  = 32;

  localparam logic [APB_AW-1:0] REG_CTRL = 32'h0000_0000;
  localparam logic [APB_AW-1:0] REG_CFG0 = 32'h0000_0004;
  localparam logic [APB_AW-1:0] REG_CFG1 = 32'h0000_0008;
  localparam logic [APB_AW-1:0] REG_LINE = 32'h0000_000C;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_OVERRUN = 1;
  localparam int unsigned STAT_ARM_ERR = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMP,
    ST_LINE_WAIT,
    ST_V1,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [VCON_DW-1:0] ndump;
    logic [VCON_DW-1:0] nlines;
    logic [VCON_DW-1:0] tdump;
    logic [VCON_DW-1:0] tgap;
  } cfg_t;

  // Zero-valued spacing registers behave as a spacing of one cycle.
  function automatic logic [VCON_DW-1:0] at_least_one(input logic [VCON_DW-1:0] v);
    return (v == '0) ? VCON_DW'(1) : v;
  endfunction

endpackage

// File: rtl/ppg_vseq_regs.sv
// APB register file: configuration, self-clearing START/ABORT strobes, sticky status.
module ppg_vseq_regs
  import ppg_pkg::*;
(
  input  logic               clk_fast,
  input  logic               rst_ccd,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [APB_AW-1:0]  paddr_i,
  input  logic [APB_DW-1:0]  pwdata_i,
  output logic               pready_o,
  output logic [APB_DW-1:0]  prdata_o,
  input  logic               busy_i,
  input  logic [VCON_DW-1:0] line_idx_i,
  input  logic               set_overrun_i,
  input  logic               set_arm_err_i,
  input  logic               clr_sticky_i,
  output logic               start_o,
  output logic               abort_o,
  output cfg_t               cfg_o
);

  logic              pready_q;
  logic [APB_DW-1:0] prdata_q;
  logic              start_q;
  logic              abort_q;
  logic              overrun_q;
  logic              arm_err_q;
  cfg_t              cfg_q;

  logic              access_c;
  logic              wr_c;
  logic              rd_c;
  logic              wr_ctrl_c;
  logic [APB_DW-1:0] rdata_c;

  // pready_q masks the access phase so each transfer completes exactly once.
  assign access_c  = psel_i & penable_i & ~pready_q;
  assign wr_c      = access_c & pwrite_i;
  assign rd_c      = access_c & ~pwrite_i;
  assign wr_ctrl_c = wr_c & (paddr_i == REG_CTRL);

  always_comb begin
    rdata_c = '0;
    case (paddr_i)
      REG_CTRL: begin
        rdata_c[STAT_BUSY]    = busy_i;
        rdata_c[STAT_OVERRUN] = overrun_q;
        rdata_c[STAT_ARM_ERR] = arm_err_q;
      end
      REG_CFG0: rdata_c = {cfg_q.ndump, cfg_q.nlines};
      REG_CFG1: rdata_c = {cfg_q.tdump, cfg_q.tgap};
      REG_LINE: rdata_c = APB_DW'(line_idx_i);
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst_ccd) begin
    if (!rst_ccd) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
      arm_err_q <= 1'b0;
      cfg_q     <= '0;
    end else begin
      pready_q <= access_c;
      prdata_q <= rd_c ? rdata_c : '0;
      // ABORT written together with START suppresses the START.
      start_q  <= wr_ctrl_c & pwdata_i[CTRL_START] & ~pwdata_i[CTRL_ABORT];
      abort_q  <= wr_ctrl_c & pwdata_i[CTRL_ABORT];

      if (wr_c && paddr_i == REG_CFG0) begin
        cfg_q.ndump  <= pwdata_i[31:16];
        cfg_q.nlines <= pwdata_i[15:0];
      end
      if (wr_c && paddr_i == REG_CFG1) begin
        cfg_q.tdump <= pwdata_i[31:16];
        cfg_q.tgap  <= pwdata_i[15:0];
      end

      if (set_overrun_i)     overrun_q <= 1'b1;
      else if (clr_sticky_i) overrun_q <= 1'b0;
      if (set_arm_err_i)     arm_err_q <= 1'b1;
      else if (clr_sticky_i) arm_err_q <= 1'b0;
    end
  end

  assign pready_o = pready_q;
  assign prdata_o = prdata_q;
  assign start_o  = start_q;
  assign abort_o  = abort_q;
  assign cfg_o    = cfg_q;

endmodule

// File: rtl/ppg_vseq.sv
// Frame-level V transfer sequencer: fast-dump V23 pulses, then one V1/V2 pair per line.
module ppg_vseq
  import ppg_pkg::*;
(
  input  logic               clk_fast,
  input  logic               rst_ccd,
  input  logic               s_apb_psel,
  input  logic               s_apb_penable,
  input  logic               s_apb_pwrite,
  input  logic [APB_AW-1:0]  s_apb_paddr,
  input  logic [APB_DW-1:0]  s_apb_pwdata,
  output logic               s_apb_pready,
  output logic [APB_DW-1:0]  s_apb_prdata,
  input  logic               hd_sync,
  input  logic               ppg_armed,
  output logic               v1_trig,
  output logic               v2_trig,
  output logic               v23_trig,
  output logic               busy,
  output logic               frame_done,
  output logic [VCON_DW-1:0] line_idx
);

  state_e             state_q, state_d;
  logic [VCON_DW-1:0] dump_cnt_q, dump_cnt_d;
  logic [VCON_DW-1:0] tmr_q, tmr_d;
  logic [VCON_DW-1:0] line_idx_q, line_idx_d;
  logic [VCON_DW-1:0] nlines_q, nlines_d;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic               v23_q, v23_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q;

  logic               start_c;
  logic               abort_c;
  cfg_t               cfg_c;
  logic               set_overrun_c;
  logic               set_arm_err_c;
  logic               clr_sticky_c;
  logic [VCON_DW-1:0] tdump_eff_c;
  logic [VCON_DW-1:0] tgap_eff_c;

  ppg_vseq_regs u_regs (
    .clk_fast      (clk_fast),
    .rst_ccd       (rst_ccd),
    .psel_i        (s_apb_psel),
    .penable_i     (s_apb_penable),
    .pwrite_i      (s_apb_pwrite),
    .paddr_i       (s_apb_paddr),
    .pwdata_i      (s_apb_pwdata),
    .pready_o      (s_apb_pready),
    .prdata_o      (s_apb_prdata),
    .busy_i        (busy_q),
    .line_idx_i    (line_idx_q),
    .set_overrun_i (set_overrun_c),
    .set_arm_err_i (set_arm_err_c),
    .clr_sticky_i  (clr_sticky_c),
    .start_o       (start_c),
    .abort_o       (abort_c),
    .cfg_o         (cfg_c)
  );

  assign tdump_eff_c = at_least_one(cfg_c.tdump);
  assign tgap_eff_c  = at_least_one(cfg_c.tgap);

  always_ff @(posedge clk_fast or negedge rst_ccd) begin
    if (!rst_ccd) begin
      state_q      <= ST_IDLE;
      dump_cnt_q   <= '0;
      tmr_q        <= '0;
      line_idx_q   <= '0;
      nlines_q     <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v23_q        <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_cnt_q   <= dump_cnt_d;
      tmr_q        <= tmr_d;
      line_idx_q   <= line_idx_d;
      nlines_q     <= nlines_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v23_q        <= v23_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Pulses are registered on the edge that enters their state, so each is
  // high during the first cycle of that state.
  always_comb begin
    state_d       = state_q;
    dump_cnt_d    = dump_cnt_q;
    tmr_d         = tmr_q;
    line_idx_d    = line_idx_q;
    nlines_d      = nlines_q;
    v1_d          = 1'b0;
    v2_d          = 1'b0;
    v23_d         = 1'b0;
    frame_done_d  = 1'b0;
    set_arm_err_c = 1'b0;
    clr_sticky_c  = 1'b0;
    set_overrun_c = hd_sync &&
                    (state_q == ST_DUMP || state_q == ST_V1 || state_q == ST_GAP);

    if (state_q != ST_IDLE && (abort_c || !ppg_armed)) begin
      state_d       = ST_IDLE;
      set_arm_err_c = ~ppg_armed;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            if (ppg_armed) begin
              clr_sticky_c = 1'b1;
              line_idx_d   = '0;
              dump_cnt_d   = '0;
              nlines_d     = cfg_c.nlines;
              if (cfg_c.ndump != '0) begin
                state_d    = ST_DUMP;
                v23_d      = 1'b1;
                dump_cnt_d = VCON_DW'(1);
                tmr_d      = tdump_eff_c;
              end else begin
                state_d = ST_LINE_WAIT;
              end
            end else begin
              set_arm_err_c = 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (tmr_q <= VCON_DW'(1)) begin
            if (dump_cnt_q >= cfg_c.ndump) begin
              state_d = ST_LINE_WAIT;
            end else begin
              v23_d      = 1'b1;
              dump_cnt_d = dump_cnt_q + VCON_DW'(1);
              tmr_d      = tdump_eff_c;
            end
          end else begin
            tmr_d = tmr_q - VCON_DW'(1);
          end
        end
        ST_LINE_WAIT: begin
          if (line_idx_q == nlines_q) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else if (hd_sync) begin
            state_d = ST_V1;
            v1_d    = 1'b1;
          end
        end
        ST_V1: begin
          state_d = ST_GAP;
          tmr_d   = tgap_eff_c;
        end
        ST_GAP: begin
          if (tmr_q <= VCON_DW'(1)) begin
            state_d    = ST_LINE_WAIT;
            v2_d       = 1'b1;
            line_idx_d = (line_idx_q == '1) ? line_idx_q : line_idx_q + VCON_DW'(1);
          end else begin
            tmr_d = tmr_q - VCON_DW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign v1_trig    = v1_q;
  assign v2_trig    = v2_q;
  assign v23_trig   = v23_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign line_idx   = line_idx_q;

endmodule

// File: tb/tb_ppg_vseq.sv
// Directed bench for ppg_vseq: trigger timing, boundaries, sticky status and reset.
module tb_ppg_vseq;
  import ppg_pkg::*;

  logic               clk_fast = 1'b0;
  logic               rst_ccd  = 1'b0;
  logic               s_apb_psel = 1'b0, s_apb_penable = 1'b0, s_apb_pwrite = 1'b0;
  logic [31:0]        s_apb_paddr = '0, s_apb_pwdata = '0;
  logic               s_apb_pready;
  logic [31:0]        s_apb_prdata;
  logic               hd_sync = 1'b0;
  logic               ppg_armed = 1'b1;
  logic               v1_trig, v2_trig, v23_trig, busy, frame_done;
  logic [VCON_DW-1:0] line_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap_n = 0;
  int v1s[$], v2s[$], v23s[$], fds[$], hds[$];

  ppg_vseq dut (
    .clk_fast      (clk_fast),
    .rst_ccd       (rst_ccd),
    .s_apb_psel    (s_apb_psel),
    .s_apb_penable (s_apb_penable),
    .s_apb_pwrite  (s_apb_pwrite),
    .s_apb_paddr   (s_apb_paddr),
    .s_apb_pwdata  (s_apb_pwdata),
    .s_apb_pready  (s_apb_pready),
    .s_apb_prdata  (s_apb_prdata),
    .hd_sync       (hd_sync),
    .ppg_armed     (ppg_armed),
    .v1_trig       (v1_trig),
    .v2_trig       (v2_trig),
    .v23_trig      (v23_trig),
    .busy          (busy),
    .frame_done    (frame_done),
    .line_idx      (line_idx)
  );

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) cyc <= cyc + 1;

  // Timestamp every output pulse on the falling edge.
  always @(negedge clk_fast) begin
    if (v1_trig)    v1s.push_back(cyc);
    if (v2_trig)    v2s.push_back(cyc);
    if (v23_trig)   v23s.push_back(cyc);
    if (frame_done) fds.push_back(cyc);
    if ((int'(v1_trig) + int'(v2_trig) + int'(v23_trig)) > 1) overlap_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic flush();
    v1s.delete(); v2s.delete(); v23s.delete(); fds.delete(); hds.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_fast);
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int done_cyc);
    int n;
    s_apb_psel = 1'b1; s_apb_pwrite = wr; s_apb_paddr = addr; s_apb_pwdata = wdata;
    s_apb_penable = 1'b0;
    @(negedge clk_fast);
    s_apb_penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk_fast);
      n++;
    end while (!s_apb_pready && n < 8);
    if (!s_apb_pready) chk("apb_ready_timeout", 32'(s_apb_pready), 32'd1);
    rdata = s_apb_prdata;
    done_cyc = cyc;
    s_apb_psel = 1'b0; s_apb_penable = 1'b0; s_apb_pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    int c;
    apb_xfer(1'b1, addr, data, d, c);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data);
    int c;
    apb_xfer(1'b0, addr, 32'h0, data, c);
  endtask

  task automatic start_frame(output int s);
    logic [31:0] d;
    apb_xfer(1'b1, 32'h0, 32'h1, d, s);
  endtask

  task automatic hd_pulse();
    hd_sync = 1'b1;
    hds.push_back(cyc);
    @(negedge clk_fast);
    hd_sync = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int s;

    // Reset values
    idle(3);
    rst_ccd = 1'b1;
    idle(2);
    chk("rst_outputs", 32'({busy, v1_trig, v2_trig, v23_trig, frame_done}), 32'd0);
    chk("rst_line_idx", 32'(line_idx), 32'd0);
    chk("rst_pready", 32'(s_apb_pready), 32'd0);
    apb_rd(32'h0, rd);  chk("rst_ctrl", rd, 32'h0);
    apb_rd(32'h4, rd);  chk("rst_cfg0", rd, 32'h0);

    // Main frame: NDUMP=2 TDUMP=4 NLINES=3 TGAP=5, hd every 50 cycles
    apb_wr(32'h4, 32'h0002_0003);
    apb_wr(32'h8, 32'h0004_0005);
    apb_rd(32'h4, rd);  chk("cfg0_rb", rd, 32'h0002_0003);
    apb_rd(32'h20, rd); chk("unmapped_rd", rd, 32'h0);
    flush();
    start_frame(s);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      hd_pulse();
      idle(49);
    end
    chk("m_v23_n", 32'(v23s.size()), 32'd2);
    chk("m_v23_first", 32'(qat(v23s, 0) - s), 32'd1);
    chk("m_v23_gap", 32'(qat(v23s, 1) - qat(v23s, 0)), 32'd4);
    chk("m_v1_n", 32'(v1s.size()), 32'd3);
    chk("m_v2_n", 32'(v2s.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m_hd_v1_%0d", i), 32'(qat(v1s, i) - qat(hds, i)), 32'd1);
      chk($sformatf("m_v1_v2_%0d", i), 32'(qat(v2s, i) - qat(v1s, i)), 32'd6);
    end
    chk("m_fd_n", 32'(fds.size()), 32'd1);
    chk("m_fd_time", 32'(qat(fds, 0) - qat(v2s, 2)), 32'd1);
    chk("m_line_idx", 32'(line_idx), 32'd3);
    chk("m_busy", 32'(busy), 32'd0);
    apb_rd(32'hC, rd);  chk("m_line_rd", rd, 32'd3);
    apb_rd(32'h0, rd);  chk("m_ctrl", rd, 32'h0);

    // Empty frame: NDUMP=0 NLINES=0
    apb_wr(32'h4, 32'h0);
    flush();
    start_frame(s);
    idle(10);
    chk("e_fd_n", 32'(fds.size()), 32'd1);
    chk("e_fd_time", 32'(qat(fds, 0) - s), 32'd2);
    chk("e_trigs", 32'(v1s.size() + v2s.size() + v23s.size()), 32'd0);

    // Zero spacing registers behave as one
    apb_wr(32'h4, 32'h0002_0001);
    apb_wr(32'h8, 32'h0);
    flush();
    start_frame(s);
    idle(10);
    hd_pulse();
    idle(10);
    chk("z_v23_gap", 32'(qat(v23s, 1) - qat(v23s, 0)), 32'd1);
    chk("z_v1_v2", 32'(qat(v2s, 0) - qat(v1s, 0)), 32'd2);
    chk("z_fd_n", 32'(fds.size()), 32'd1);

    // hd during GAP flags OVERRUN and gives no extra line
    apb_wr(32'h4, 32'h0000_0002);
    apb_wr(32'h8, 32'h0000_000A);
    flush();
    start_frame(s);
    idle(10);
    hd_pulse();
    idle(3);
    hd_pulse();
    idle(20);
    hd_pulse();
    idle(20);
    chk("o_v1_n", 32'(v1s.size()), 32'd2);
    chk("o_v2_n", 32'(v2s.size()), 32'd2);
    apb_rd(32'h0, rd);  chk("o_ctrl", rd, 32'h2);

    // ppg_armed dropped mid-line acts as abort
    apb_wr(32'h4, 32'h0000_0003);
    apb_wr(32'h8, 32'h0000_0014);
    flush();
    start_frame(s);
    idle(5);
    hd_pulse();
    idle(4);
    ppg_armed = 1'b0;
    idle(1);
    chk("a_busy_next", 32'(busy), 32'd0);
    idle(10);
    hd_pulse();
    idle(30);
    chk("a_v1_n", 32'(v1s.size()), 32'd1);
    chk("a_v2_n", 32'(v2s.size()), 32'd0);
    chk("a_fd_n", 32'(fds.size()), 32'd0);
    chk("a_line_idx", 32'(line_idx), 32'd0);
    apb_rd(32'h0, rd);  chk("a_ctrl", rd, 32'h4);

    // START while unarmed, then ABORT+START together: neither starts a frame
    start_frame(s);
    idle(5);
    chk("u_busy", 32'(busy), 32'd0);
    ppg_armed = 1'b1;
    apb_wr(32'h0, 32'h3);
    idle(5);
    chk("as_busy", 32'(busy), 32'd0);
    apb_rd(32'h0, rd);  chk("as_ctrl", rd, 32'h4);

    // Asynchronous reset in the middle of the second line's GAP
    apb_wr(32'h4, 32'h0000_0002);
    flush();
    start_frame(s);
    idle(5);
    hd_pulse();
    idle(30);
    chk("r_line1", 32'(line_idx), 32'd1);
    hd_pulse();
    idle(5);
    chk("r_busy_pre", 32'(busy), 32'd1);
    #2 rst_ccd = 1'b0;
    #1;
    chk("r_outputs", 32'({busy, v1_trig, v2_trig, v23_trig, frame_done}), 32'd0);
    chk("r_line_idx", 32'(line_idx), 32'd0);
    idle(2);
    rst_ccd = 1'b1;
    idle(2);
    apb_rd(32'h0, rd);  chk("r_ctrl", rd, 32'h0);
    apb_rd(32'h4, rd);  chk("r_cfg0", rd, 32'h0);
    apb_rd(32'h8, rd);  chk("r_cfg1", rd, 32'h0);
    apb_rd(32'hC, rd);  chk("r_line_rd", rd, 32'h0);

    chk("no_overlap", 32'(overlap_n), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
